// File: rtl/xmem_ctrl.sv
// Host-port arbiter and engine-run sequencer for one xmem unit.
// Round-robin between two masters, tag pipe for read returns, run/flush/drain FSM.
`ifndef MEM_ADDR_W
`define MEM_ADDR_W 10
`endif

module xmem_ctrl #(
  parameter int MEM_ADDR_W = `MEM_ADDR_W,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_req,
  output logic                  run_ack,
  output logic                  busy,
  input  logic                  m0_valid,
  input  logic                  m0_we,
  input  logic [MEM_ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic                  m0_ready,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_valid,
  input  logic                  m1_we,
  input  logic [MEM_ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  output logic                  m1_ready,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  mem_run,
  input  logic                  mem_done,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [2:0] {IDLE, FLUSH, START, RUN, DRAIN} state_t;

  state_t            state;
  logic              last_m1;
  logic [1:0]        run_cnt;
  logic [RD_LAT-1:0] vld_p;
  logic [RD_LAT-1:0] id_p;
  logic              host_en;
  logic              gnt0;
  logic              gnt1;
  logic              rd_acc;

  // Grants are only made in IDLE with no run pending, so a run never races a host access.
  always_comb begin
    host_en = !rst && (state == IDLE) && !run_req;
    gnt0    = host_en && m0_valid && (!m1_valid || last_m1);
    gnt1    = host_en && m1_valid && (!m0_valid || !last_m1);
  end

  assign m0_ready  = gnt0;
  assign m1_ready  = gnt1;
  assign mem_valid = gnt0 | gnt1;
  assign mem_we    = (gnt0 & m0_we) | (gnt1 & m1_we);
  assign mem_addr  = gnt1 ? m1_addr  : m0_addr;
  assign mem_wdata = gnt1 ? m1_wdata : m0_wdata;
  assign rd_acc    = mem_valid & ~mem_we;

  assign m0_rvalid = vld_p[RD_LAT-1] & ~id_p[RD_LAT-1];
  assign m1_rvalid = vld_p[RD_LAT-1] &  id_p[RD_LAT-1];
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

  // Tag pipe stage p0 .. p(RD_LAT-1): master id is data, only the valid bits are reset.
  always_ff @(posedge clk) begin
    id_p[0] <= gnt1;
    for (int i = 1; i < RD_LAT; i++) id_p[i] <= id_p[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= rd_acc;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Run sequencer; mem_run/run_ack/busy are registered on entry to the state that owns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mem_run <= 1'b0;
      run_ack <= 1'b0;
      busy    <= 1'b0;
      run_cnt <= 2'd0;
      last_m1 <= 1'b1;
    end else begin
      mem_run <= 1'b0;
      run_ack <= 1'b0;
      if (gnt0 || gnt1) last_m1 <= gnt1;
      case (state)
        IDLE: begin
          if (run_req) state <= FLUSH;
        end
        FLUSH: begin
          if (vld_p == '0) begin
            state   <= START;
            mem_run <= 1'b1;
            run_ack <= 1'b1;
            busy    <= 1'b1;
          end
        end
        START: begin
          state   <= RUN;
          run_cnt <= 2'd0;
        end
        RUN: begin
          // done may still show the previous idle level for the first two cycles
          if (run_cnt != 2'd2) run_cnt <= run_cnt + 2'd1;
          else if (mem_done)   state   <= DRAIN;
        end
        DRAIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
